aes_key_schedule: RTL and testbench

- Sequential AES-128 key-schedule engine that accepts a cipher key over a valid/ready handshake.
- Iterates the existing single-step KeyExpansion function once per clock, deriving round keys 1..10.
- Stores all 11 round keys (0..10) in an internal register file and serves them to the downstream cipher round datapath (AddRoundKey).
- Streams each key as it is produced and provides a random-access read port.

---
 rtl/aes_key_schedule.sv | 225 ++++++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// ============================================================================
//  Module   : aes_key_schedule
//  Purpose  : Sequential AES-128 key-schedule engine. Accepts a cipher key
//             over a valid/ready handshake, derives round keys 1..10 at one
//             expansion step per clock, stores all 11 round keys and serves
//             them both as a stream and through a registered read port.
//  Ports    : clk, rst                - clock, synchronous active-high reset
//             key_in/key_valid/key_ready - cipher key handshake (w0 = [127:96])
//             busy, done, keys_ready  - status (done is a one-cycle pulse)
//             rk_valid/rk_idx/rk_data - round-key stream, no backpressure
//             rd_idx/rd_key           - random-access read, 1-cycle latency
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         done,
    output logic         keys_ready,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_data,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam logic [3:0] c_last_idx  = 4'(NR);
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_expand = 2'd1;
    localparam logic [1:0] c_st_ready  = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic [3:0]   r_cnt;
    logic [127:0] r_rk [0:NR];

    logic         r_busy;
    logic         r_done;
    logic         r_keys_ready;
    logic         r_rk_valid;
    logic [3:0]   r_rk_idx;
    logic [127:0] r_rk_data;
    logic [127:0] r_rd_key;

    logic         w_key_ready;
    logic         w_accept;
    logic [7:0]   w_rcon;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_temp;
    logic [31:0]  w_w0;
    logic [31:0]  w_w1;
    logic [31:0]  w_w2;
    logic [31:0]  w_w3;
    logic [127:0] w_next_key;

    // ------------------------------------------------------------------
    // GF(2^8) helpers. The S-box is computed as the multiplicative inverse
    // (x^254) followed by the AES affine transform, which avoids a 256-entry
    // table per byte lane.
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = f_xtime(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        // x^254 = x^2 * x^4 * ... * x^128 ; zero maps to zero as required
        for (int i = 1; i < 8; i++) begin
            sq  = f_gmul(sq, sq);
            inv = f_gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // ------------------------------------------------------------------
    // Single KeyExpansion step. During EXPAND, r_rk_data always holds
    // rk[r_cnt-1] because it is the key streamed on the previous edge, so it
    // serves as the step input without a wide read mux on the key store.
    // ------------------------------------------------------------------
    assign w_rot = {r_rk_data[23:0], r_rk_data[31:24]};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_subword
            assign w_sub[8*i +: 8] = f_sbox(w_rot[8*i +: 8]);
        end
    endgenerate

    always_comb begin
        w_rcon = 8'h00;
        case (r_cnt)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_temp     = w_sub ^ {w_rcon, 24'h000000};
    assign w_w0       = r_rk_data[127:96] ^ w_temp;
    assign w_w1       = r_rk_data[95:64]  ^ w_w0;
    assign w_w2       = r_rk_data[63:32]  ^ w_w1;
    assign w_w3       = r_rk_data[31:0]   ^ w_w2;
    assign w_next_key = {w_w0, w_w1, w_w2, w_w3};

    // ------------------------------------------------------------------
    // FSM: state register / next state / combinational outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle,
            c_st_ready:  if (w_accept) w_state_next = c_st_expand;
            c_st_expand: if (r_cnt == c_last_idx) w_state_next = c_st_ready;
            default:     w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_key_ready = !rst && ((r_state == c_st_idle) || (r_state == c_st_ready));
        w_accept    = key_valid && w_key_ready;
    end

    // ------------------------------------------------------------------
    // Key store, stream and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) begin
                r_rk[i] <= '0;
            end
            r_cnt        <= 4'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_ready <= 1'b0;
            r_rk_valid   <= 1'b0;
            r_rk_idx     <= 4'd0;
            r_rk_data    <= '0;
            r_rd_key     <= '0;
        end else begin
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;

            if (w_accept) begin
                r_rk[0]      <= key_in;
                r_cnt        <= 4'd1;
                r_busy       <= 1'b1;
                r_keys_ready <= 1'b0;
                r_rk_valid   <= 1'b1;
                r_rk_idx     <= 4'd0;
                r_rk_data    <= key_in;
            end else if (r_state == c_st_expand) begin
                r_rk[r_cnt] <= w_next_key;
                r_rk_valid  <= 1'b1;
                r_rk_idx    <= r_cnt;
                r_rk_data   <= w_next_key;
                if (r_cnt == c_last_idx) begin
                    r_cnt        <= 4'd0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b1;
                    r_keys_ready <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end

            // Non-blocking read: a same-edge write is not visible yet.
            if (rd_idx <= c_last_idx) begin
                r_rd_key <= r_rk[rd_idx];
            end else begin
                r_rd_key <= '0;
            end
        end
    end

    assign key_ready  = w_key_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign keys_ready = r_keys_ready;
    assign rk_valid   = r_rk_valid;
    assign rk_idx     = r_rk_idx;
    assign rk_data    = r_rk_data;
    assign rd_key     = r_rd_key;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
// ============================================================================
//  Module   : tb_aes_key_schedule
//  Purpose  : Self-checking bench for aes_key_schedule using FIPS-197 and
//             all-zero key reference schedules with a stream scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic         keys_ready;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic [3:0]   rd_idx = 4'd0;
    logic [127:0] rd_key;

    aes_key_schedule #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .done       (done),
        .keys_ready (keys_ready),
        .rk_valid   (rk_valid),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] c_fips_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_other_key = 128'h00112233445566778899aabbccddeeff;

    logic [127:0] fips_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    logic [127:0] zero_rk [0:10] = '{
        128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    typedef struct {
        int           c;
        logic [3:0]   idx;
        logic [127:0] data;
    } obs_t;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] data;
    } exp_t;

    obs_t obs_q[$];
    exp_t exp_q[$];
    int   done_q[$];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every stream strobe and done pulse with its cycle stamp.
    always @(negedge clk) begin
        if (rk_valid) begin
            obs_t o;
            o.c    = cyc;
            o.idx  = rk_idx;
            o.data = rk_data;
            obs_q.push_back(o);
        end
        if (done) done_q.push_back(cyc);
    end

    function automatic void push_exp(input bit zero_key);
        for (int k = 0; k < 11; k++) begin
            exp_t e;
            e.idx  = 4'(k);
            e.data = zero_key ? zero_rk[k] : fips_rk[k];
            exp_q.push_back(e);
        end
    endfunction

    function automatic void flush();
        obs_q.delete();
        exp_q.delete();
        done_q.delete();
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        ok = done;
    endtask

    task automatic wait_keys_ready(output bit ok);
        int n = 0;
        while (!keys_ready && n < 40) begin
            step();
            n++;
        end
        ok = keys_ready;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        key_valid = 1'b0;
        step();
        step();
        checks++;
        if ({busy, done, keys_ready, rk_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got busy/done/keys_ready/rk_valid=%b want 0000",
                     {busy, done, keys_ready, rk_valid});
        end
        checks++;
        if (rk_idx !== 4'd0 || rk_data !== 128'h0) begin
            failures++;
            $display("FAIL reset_stream got idx=%0d data=%h want 0/0", rk_idx, rk_data);
        end
        checks++;
        if (rd_key !== 128'h0) begin
            failures++;
            $display("FAIL reset_rd_key got %h want 0", rd_key);
        end
        checks++;
        if (key_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_key_ready_in_rst got %b want 0", key_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (key_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_key_ready_after got %b want 1", key_ready);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_fips();
        bit ok;
        flush();
        key_in = c_fips_key;
        key_valid = 1'b1;
        checks++;
        if (key_ready !== 1'b1) begin
            failures++;
            $display("FAIL fips_key_ready got %b want 1", key_ready);
        end
        push_exp(1'b0);
        step();
        key_valid = 1'b0;
        acc_cyc = cyc;
        checks++;
        if (busy !== 1'b1 || rk_valid !== 1'b1 || rk_idx !== 4'd0) begin
            failures++;
            $display("FAIL fips_start got busy=%b rk_valid=%b idx=%0d want 1 1 0", busy, rk_valid, rk_idx);
        end
        wait_done(ok);
        checks++;
        if (!ok || keys_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fips_done got done=%b keys_ready=%b busy=%b want 1 1 0", done, keys_ready, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || keys_ready !== 1'b1) begin
            failures++;
            $display("FAIL fips_after got done=%b keys_ready=%b want 0 1", done, keys_ready);
        end
        checks++;
        if (obs_q.size() != 11) begin
            failures++;
            $display("FAIL fips_stream_len got %0d want 11", obs_q.size());
        end
        for (int k = 0; k < 11 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            obs_t o;
            exp_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.idx !== e.idx || o.data !== e.data || o.c != acc_cyc + k) begin
                failures++;
                $display("FAIL fips_stream[%0d] got idx=%0d data=%h cyc=%0d want idx=%0d data=%h cyc=%0d",
                         k, o.idx, o.data, o.c, e.idx, e.data, acc_cyc + k);
            end
        end
        checks++;
        if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != acc_cyc + 10)) begin
            failures++;
            $display("FAIL fips_done_pulse got count=%0d want one pulse at cyc %0d", done_q.size(), acc_cyc + 10);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_zero();
        bit ok;
        flush();
        key_in = 128'h0;
        key_valid = 1'b1;
        checks++;
        if (key_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_key_ready_in_ready got %b want 1", key_ready);
        end
        push_exp(1'b1);
        step();
        key_valid = 1'b0;
        acc_cyc = cyc;
        checks++;
        if (keys_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_keys_ready_drop got %b want 0", keys_ready);
        end
        wait_keys_ready(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL zero_complete got keys_ready=%b want 1", keys_ready);
        end
        step();
        for (int k = 0; k < 11 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            obs_t o;
            exp_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.idx !== e.idx || o.data !== e.data || o.c != acc_cyc + k) begin
                failures++;
                $display("FAIL zero_stream[%0d] got idx=%0d data=%h cyc=%0d want idx=%0d data=%h cyc=%0d",
                         k, o.idx, o.data, o.c, e.idx, e.data, acc_cyc + k);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL zero_stream_missing got %0d unmatched want 0", exp_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            logic [127:0] want;
            want = '0;
            if (i <= 10) want = zero_rk[i];
            rd_idx = 4'(i);
            step();
            checks++;
            if (rd_key !== want) begin
                failures++;
                $display("FAIL zero_rd[%0d] got %h want %h", i, rd_key, want);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_hold();
        bit ok;
        flush();
        key_in = c_fips_key;
        key_valid = 1'b1;
        push_exp(1'b0);
        step();
        acc_cyc = cyc;
        key_in = c_other_key;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (key_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_key_ready[%0d] got %b want 0", k, key_ready);
            end
            if (k == 9) key_valid = 1'b0;
            step();
        end
        checks++;
        if (done !== 1'b1 || keys_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_done got done=%b keys_ready=%b want 1 1", done, keys_ready);
        end
        step();
        for (int k = 0; k < 11 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            obs_t o;
            exp_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.idx !== e.idx || o.data !== e.data || o.c != acc_cyc + k) begin
                failures++;
                $display("FAIL hold_stream[%0d] got idx=%0d data=%h cyc=%0d want idx=%0d data=%h cyc=%0d",
                         k, o.idx, o.data, o.c, e.idx, e.data, acc_cyc + k);
            end
        end
        checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL hold_stream_len got extra=%0d missing=%0d want 0 0", obs_q.size(), exp_q.size());
        end
        // second key offered while READY
        flush();
        key_in = 128'h0;
        key_valid = 1'b1;
        checks++;
        if (key_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_ready_accept got key_ready=%b want 1", key_ready);
        end
        step();
        key_valid = 1'b0;
        checks++;
        if (keys_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_rekey_start got keys_ready=%b busy=%b want 0 1", keys_ready, busy);
        end
        wait_keys_ready(ok);
        rd_idx = 4'd10;
        step();
        checks++;
        if (!ok || rd_key !== zero_rk[10]) begin
            failures++;
            $display("FAIL hold_rekey_rk10 got ok=%b rd_key=%h want 1 %h", ok, rd_key, zero_rk[10]);
        end
        flush();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        flush();
        key_in = c_fips_key;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_busy_before got %b want 1", busy);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({busy, done, keys_ready, rk_valid, key_ready} !== 5'b00000) begin
            failures++;
            $display("FAIL rstmid_flags got busy/done/keys_ready/rk_valid/key_ready=%b want 00000",
                     {busy, done, keys_ready, rk_valid, key_ready});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (key_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_key_ready got %b want 1", key_ready);
        end
        for (int i = 0; i <= 10; i++) begin
            rd_idx = 4'(i);
            step();
            checks++;
            if (rd_key !== 128'h0) begin
                failures++;
                $display("FAIL rstmid_rd[%0d] got %h want 0", i, rd_key);
            end
        end
        checks++;
        if (done_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_no_done got %0d pulses want 0", done_q.size());
        end
        flush();
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        bit ok;
        flush();
        key_in = c_fips_key;
        key_valid = 1'b1;
        push_exp(1'b0);
        step();
        key_valid = 1'b0;
        acc_cyc = cyc;
        wait_done(ok);
        checks++;
        if (!ok || key_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_done got done=%b key_ready=%b want 1 1", done, key_ready);
        end
        key_in = 128'h0;
        key_valid = 1'b1;
        push_exp(1'b1);
        step();
        key_valid = 1'b0;
        checks++;
        if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || busy !== 1'b1 || rk_data !== 128'h0) begin
            failures++;
            $display("FAIL b2b_restart got rk_valid=%b idx=%0d busy=%b data=%h want 1 0 1 0",
                     rk_valid, rk_idx, busy, rk_data);
        end
        wait_keys_ready(ok);
        step();
        checks++;
        if (!ok || obs_q.size() != 22) begin
            failures++;
            $display("FAIL b2b_stream_len got ok=%b len=%0d want 1 22", ok, obs_q.size());
        end
        for (int k = 0; k < 22 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            obs_t o;
            exp_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.idx !== e.idx || o.data !== e.data || o.c != acc_cyc + k) begin
                failures++;
                $display("FAIL b2b_stream[%0d] got idx=%0d data=%h cyc=%0d want idx=%0d data=%h cyc=%0d",
                         k, o.idx, o.data, o.c, e.idx, e.data, acc_cyc + k);
            end
        end
        checks++;
        if (done_q.size() != 2 ||
            (done_q.size() == 2 && (done_q[0] != acc_cyc + 10 || done_q[1] != acc_cyc + 21))) begin
            failures++;
            $display("FAIL b2b_done_pulses got count=%0d want 2 at cyc %0d,%0d",
                     done_q.size(), acc_cyc + 10, acc_cyc + 21);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_fips();
        test_zero();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no completion want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
